// File: rtl/icache_set_assoc_if.sv
// Fetch-side and memory-side request/response signals of icache_set_assoc.
// slave is the cache view; master is the fetch + memory environment view.
interface icache_set_assoc_if;
  logic        read_request;
  logic [31:0] addr;
  logic        read_response;
  logic [31:0] read_data;
  logic        memory_read_request;
  logic [31:0] memory_addr;
  logic        memory_read_response;
  logic [31:0] memory_read_data;

  modport slave (
    input  read_request,
    input  addr,
    output read_response,
    output read_data,
    output memory_read_request,
    output memory_addr,
    input  memory_read_response,
    input  memory_read_data
  );

  modport master (
    output read_request,
    output addr,
    input  read_response,
    input  read_data,
    input  memory_read_request,
    input  memory_addr,
    output memory_read_response,
    output memory_read_data
  );
endinterface

// File: rtl/icache_set_assoc.sv
// Set-associative I-cache: WAYS x SETS lines of LINE_WORDS words, word-serial refill.
// Define ICACHE_FLUSH_EN to build the invalidate-all flush logic.
module icache_set_assoc #(
  parameter int WAYS       = 2,
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  icache_set_assoc_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;

  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [SETS-1:0][WAY_W-1:0] victim_q;
  logic [TAG_W-1:0]           tag_q  [WAYS][SETS];
  logic [31:0]                data_q [WAYS][SETS][LINE_WORDS];

  logic [OFF_W-1:0] cnt;
  logic [WAY_W-1:0] fill_way;

  logic        rsp_q;
  logic [31:0] rdata_q;
  logic        mreq_q;
  logic [31:0] maddr_q;

  logic            flush_now;
  logic            accept;
  logic            mem_ack;
  logic            last_word;
  logic [WAYS-1:0] hit_vec;
  logic            hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] fill_sel;
  logic [31:0]     hit_word;

  assign bus.read_response       = rsp_q;
  assign bus.read_data           = rdata_q;
  assign bus.memory_read_request = mreq_q;
  assign bus.memory_addr         = maddr_q;

  function automatic logic [WAY_W-1:0] next_way(
    input logic [WAY_W-1:0] w
  );
    return (WAYS == 1) ? '0 : w + 1'b1;
  endfunction

  function automatic logic [WAYS-1:0] way_mask(
    input logic [WAY_W-1:0] w
  );
    logic [WAYS-1:0] m;
    m = '0;
    for (int i = 0; i < WAYS; i++)
      m[i] = (WAY_W'(i) == w);
    return m;
  endfunction

  // Descending scan so the lowest-index hit / invalid way wins.
  always_comb begin
    hit_vec  = '0;
    hit_way  = '0;
    hit_word = '0;
    fill_sel = victim_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_q[req_idx][w] &&
                   (tag_q[w][req_idx] == req_tag);
      if (hit_vec[w]) begin
        hit_way  = WAY_W'(w);
        hit_word = data_q[w][req_idx][req_off];
      end
      if (!valid_q[req_idx][w])
        fill_sel = WAY_W'(w);
    end
  end

  assign hit       = |hit_vec;
  assign last_word = (cnt == OFF_W'(LINE_WORDS - 1));
  assign mem_ack   = (state == REFILL) && mreq_q &&
                     bus.memory_read_response;
  assign accept    = (state == IDLE) && bus.read_request &&
                     !rsp_q && !flush_now;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = hit ? IDLE : REFILL;
      REFILL:  if (mem_ack && last_word) state_nxt = LOOKUP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_tag  <= '0;
      req_idx  <= '0;
      req_off  <= '0;
      valid_q  <= '0;
      victim_q <= '0;
      cnt      <= '0;
      fill_way <= '0;
      rsp_q    <= 1'b0;
      rdata_q  <= '0;
      mreq_q   <= 1'b0;
      maddr_q  <= '0;
    end else begin
      rsp_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept)
            {req_tag, req_idx, req_off} <= bus.addr[31:2];
        end
        LOOKUP: begin
          if (hit) begin
            rsp_q              <= 1'b1;
            rdata_q            <= hit_word;
            victim_q[req_idx]  <= next_way(hit_way);
          end else begin
            valid_q[req_idx] <= valid_q[req_idx] &
                                ~way_mask(fill_sel);
            fill_way         <= fill_sel;
            cnt              <= '0;
          end
        end
        REFILL: begin
          // Request is low for one cycle between words.
          if (mem_ack) begin
            mreq_q <= 1'b0;
            cnt    <= cnt + 1'b1;
            if (last_word) begin
              valid_q[req_idx]  <= valid_q[req_idx] |
                                   way_mask(fill_way);
              victim_q[req_idx] <= next_way(fill_way);
            end
          end else if (!mreq_q) begin
            mreq_q  <= 1'b1;
            maddr_q <= {req_tag, req_idx, cnt, 2'b00};
          end
        end
        default: ;
      endcase
      if (flush_now) begin
        valid_q  <= '0;
        victim_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_ack) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == fill_way) begin
          data_q[w][req_idx][cnt] <= bus.memory_read_data;
          if (last_word)
            tag_q[w][req_idx] <= req_tag;
        end
      end
    end
  end

`ifdef ICACHE_FLUSH_EN
  // A flush seen mid-access waits until the pending response is out.
  logic flush_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              flush_pend <= 1'b0;
    else if (state == IDLE)  flush_pend <= 1'b0;
    else if (flush)          flush_pend <= 1'b1;
  end

  assign flush_now = (state == IDLE) && (flush || flush_pend);

  logic unused;
  assign unused = ^bus.addr[1:0];
`else
  assign flush_now = 1'b0;

  logic unused;
  assign unused = ^{flush, bus.addr[1:0]};
`endif

endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc: default 2-way build plus a 1-way/4-set/2-word build.
// Memory responders answer each refill word after mem_delay cycles with memf(addr).
module tb_icache_set_assoc;
  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic flush  = 1'b0;
  logic flush2 = 1'b0;

  always #5 clk = ~clk;

  icache_set_assoc_if b1 ();
  icache_set_assoc_if b2 ();

  icache_set_assoc dut1 (
    .clk   (clk),
    .reset (rst_n),
    .flush (flush),
    .bus   (b1.slave)
  );

  icache_set_assoc #(
    .WAYS       (1),
    .SETS       (4),
    .LINE_WORDS (2)
  ) dut2 (
    .clk   (clk),
    .reset (rst_n),
    .flush (flush2),
    .bus   (b2.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory model for dut1
  int          mem_delay  = 0;
  int          wcnt1      = 0;
  int          stable_err = 0;
  bit          done1      = 1'b0;
  logic [31:0] hold1;
  logic [31:0] log1[$];

  always @(negedge clk) begin
    b1.memory_read_response = 1'b0;
    if (!b1.memory_read_request) begin
      done1 = 1'b0;
      wcnt1 = 0;
    end else if (!done1) begin
      if (wcnt1 == 0) hold1 = b1.memory_addr;
      else if (b1.memory_addr !== hold1) stable_err++;
      if (wcnt1 >= mem_delay) begin
        b1.memory_read_response = 1'b1;
        b1.memory_read_data     = memf(b1.memory_addr);
        log1.push_back(b1.memory_addr);
        done1 = 1'b1;
      end else begin
        wcnt1++;
      end
    end
  end

  // Memory model for dut2, zero added latency
  int n2    = 0;
  bit done2 = 1'b0;

  always @(negedge clk) begin
    b2.memory_read_response = 1'b0;
    if (!b2.memory_read_request) begin
      done2 = 1'b0;
    end else if (!done2) begin
      b2.memory_read_response = 1'b1;
      b2.memory_read_data     = memf(b2.memory_addr);
      n2++;
      done2 = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns data, cycles from request to response, refill words used.
  task automatic do_read(input int sel, input logic [31:0] a,
                         output logic [31:0] d, output int cyc,
                         output int nw);
    bit seen;
    int base;
    seen = 1'b0;
    d    = 'x;
    cyc  = -1;
    base = (sel == 0) ? log1.size() : n2;
    @(negedge clk);
    if (sel == 0) begin
      b1.addr = a; b1.read_request = 1'b1;
    end else begin
      b2.addr = a; b2.read_request = 1'b1;
    end
    for (int k = 1; k <= 400 && !seen; k++) begin
      @(posedge clk);
      #1;
      if ((sel == 0) ? b1.read_response : b2.read_response) begin
        seen = 1'b1;
        cyc  = k;
        d    = (sel == 0) ? b1.read_data : b2.read_data;
      end
    end
    @(negedge clk);
    b1.read_request = 1'b0;
    b2.read_request = 1'b0;
    nw = ((sel == 0) ? log1.size() : n2) - base;
  endtask

  task automatic rd(input string tag, input int sel,
                    input logic [31:0] a, input int exp_words,
                    input int exp_cyc);
    logic [31:0] d;
    int          cyc;
    int          nw;
    do_read(sel, a, d, cyc, nw);
    chk({tag, "_data"},  d, memf(a));
    chk({tag, "_words"}, nw, exp_words);
    chk({tag, "_lat"},   cyc, exp_cyc);
  endtask

  initial begin
    bit found;
    int base;
    int fl_words;
    int fl_cyc;
    b1.read_request = 1'b0;
    b1.addr         = '0;
    b2.read_request = 1'b0;
    b2.addr         = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp",   b1.read_response, 0);
    chk("rst_rdata", b1.read_data, 0);
    chk("rst_mreq",  b1.memory_read_request, 0);
    chk("rst_maddr", b1.memory_addr, 0);
    chk("rst_rsp2",  b2.read_response, 0);
    rst_n = 1'b1;

    // Reset while the third word of 0x100 is being fetched
    mem_delay = 3;
    base      = log1.size();
    found     = 1'b0;
    @(negedge clk);
    b1.addr         = 32'h100;
    b1.read_request = 1'b1;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk);
      #2;
      if (log1.size() == base + 2 && b1.memory_read_request)
        found = 1'b1;
    end
    chk("rst_reach3", found, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mreq_async", b1.memory_read_request, 0);
    chk("rst_rsp_async",  b1.read_response, 0);
    b1.read_request = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    mem_delay = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_norsp", b1.read_response, 0);
    chk("rst_noreq", b1.memory_read_request, 0);

    // Cold miss: full line refill in word order
    base = log1.size();
    rd("cold", 0, 32'h100, 4, 11);
    for (int i = 0; i < 4; i++)
      chk("cold_order",
          (base + i < log1.size()) ? log1[base + i] : 32'hxxxx_xxxx,
          32'h100 + 32'(4 * i));
    chk("cold_lit", memf(32'h100), 32'h5B5A_0100);
    rd("hit10c", 0, 32'h10C, 0, 2);

    // Conflicts in set 0
    rd("c000a", 0, 32'h000, 4, 11);
    rd("c200a", 0, 32'h200, 4, 11);
    rd("c000b", 0, 32'h000, 0, 2);
    rd("c400",  0, 32'h400, 4, 11);
    rd("c000c", 0, 32'h000, 0, 2);
    rd("c200b", 0, 32'h200, 4, 11);

    // Slow memory: 4 * (5 + 2) + 3 cycles
    mem_delay = 5;
    rd("slow", 0, 32'h300, 4, 31);
    chk("slow_hold", stable_err, 0);
    mem_delay = 0;

    // Flush then re-read a resident line
`ifdef ICACHE_FLUSH_EN
    fl_words = 4;
    fl_cyc   = 11;
`else
    fl_words = 0;
    fl_cyc   = 2;
`endif
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rd("flush", 0, 32'h100, fl_words, fl_cyc);

    // Direct-mapped, 2-word lines: 0x00 and 0x20 share set 0
    rd("dm00a", 1, 32'h00, 2, 7);
    rd("dm20",  1, 32'h20, 2, 7);
    rd("dm00b", 1, 32'h00, 2, 7);
    rd("dm04",  1, 32'h04, 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
